load_store_unit: RTL

- Data-memory side of the decoder's mem_write / mem_width control outputs.
- Takes one load or store request from the datapath and checks alignment and width.
- Drives a single-outstanding req/ready memory bus with byte strobes and aligns/extends load data.
- Returns one done pulse per request; the core stalls on busy.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/lsu_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared memory-access encodings and LSU state type for the core datapath.
// Width codes follow the funct3 field of RISC-V load/store instructions.
package riscv_pkg;

    localparam logic [2:0] MW_B  = 3'b000;
    localparam logic [2:0] MW_H  = 3'b001;
    localparam logic [2:0] MW_W  = 3'b010;
    localparam logic [2:0] MW_BU = 3'b100;
    localparam logic [2:0] MW_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_FINISH,
        LSU_FAULT
    } lsu_state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic store_width_ok(input logic [2:0] width);
        return (width == MW_B) || (width == MW_H) || (width == MW_W);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding req/ready data-memory bus between the LSU and memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads; also flags illegal widths and misaligned halfword/word accesses.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  addr,
    input  logic [31:0] write_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic        misaligned_or_illegal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = bus_rdata[{addr, 3'b000} +: 8];
    assign half_lane = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        wstrb                 = 4'b0000;
        wdata                 = write_data;
        load_value            = bus_rdata;
        misaligned_or_illegal = 1'b0;
        case (width)
            MW_B: begin
                wstrb      = 4'b0001 << addr;
                wdata      = {4{write_data[7:0]}};
                load_value = {{24{byte_lane[7]}}, byte_lane};
            end
            MW_BU: begin
                wstrb      = 4'b0001 << addr;
                wdata      = {4{write_data[7:0]}};
                load_value = {24'h000000, byte_lane};
            end
            MW_H: begin
                misaligned_or_illegal = addr[0];
                wstrb      = 4'b0011 << addr;
                wdata      = {2{write_data[15:0]}};
                load_value = {{16{half_lane[15]}}, half_lane};
            end
            MW_HU: begin
                misaligned_or_illegal = addr[0];
                wstrb      = 4'b0011 << addr;
                wdata      = {2{write_data[15:0]}};
                load_value = {16'h0000, half_lane};
            end
            MW_W: begin
                misaligned_or_illegal = (addr != 2'b00);
                wstrb      = 4'b1111;
                wdata      = write_data;
                load_value = bus_rdata;
            end
            default: misaligned_or_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates one request, runs it over the memory bus with
// an optional ready timeout, and reports a single done/error pulse.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_write,
    input  logic [2:0]        mem_width,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              done,
    output logic              error,
    output logic              busy,
    load_store_unit_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t       state;
    logic [2:0]       width_q;
    logic             store_q;
    logic [1:0]       offset_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [2:0]  align_width;
    logic [1:0]  align_offset;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic [31:0] load_value;
    logic        align_fault;
    logic        request_fault;
    logic        timed_out;

    // The aligner checks the incoming request while idle and decodes the
    // latched request while the access is in flight.
    assign align_width  = (state == LSU_IDLE) ? mem_width : width_q;
    assign align_offset = (state == LSU_IDLE) ? address[1:0] : offset_q;

    lsu_align u_align (
        .width                 (align_width),
        .addr                  (align_offset),
        .write_data            (write_data),
        .bus_rdata             (bus.bus_rdata),
        .wstrb                 (align_wstrb),
        .wdata                 (align_wdata),
        .load_value            (load_value),
        .misaligned_or_illegal (align_fault)
    );

    assign request_fault = align_fault | (mem_write & ~store_width_ok(mem_width));
    assign timed_out     = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign busy          = (state != LSU_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LSU_IDLE;
            width_q       <= 3'b000;
            store_q       <= 1'b0;
            offset_q      <= 2'b00;
            wait_cnt      <= '0;
            read_data     <= 32'h0;
            done          <= 1'b0;
            error         <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wstrb <= 4'b0000;
            bus.bus_wdata <= 32'h0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        width_q  <= mem_width;
                        store_q  <= mem_write;
                        offset_q <= address[1:0];
                        wait_cnt <= '0;
                        if (request_fault) begin
                            state <= LSU_FAULT;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state         <= LSU_ACCESS;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_write;
                            bus.bus_addr  <= {address[ADDR_W-1:2], 2'b00};
                            bus.bus_wstrb <= mem_write ? align_wstrb : 4'b0000;
                            bus.bus_wdata <= mem_write ? align_wdata : 32'h0;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (bus.bus_ready) begin
                        state         <= LSU_FINISH;
                        done          <= 1'b1;
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_wstrb <= 4'b0000;
                        if (!store_q) begin
                            read_data <= load_value;
                        end
                    end else if (timed_out) begin
                        state         <= LSU_FAULT;
                        done          <= 1'b1;
                        error         <= 1'b1;
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_wstrb <= 4'b0000;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                LSU_FINISH: state <= LSU_IDLE;
                LSU_FAULT:  state <= LSU_IDLE;
                default:    state <= LSU_IDLE;
            endcase
        end
    end

endmodule
